// File: rtl/as_gpio_irq_ctrl.sv
// GPIO interrupt controller: sticky W1C pending bits, enable mask, level IRQ with lowest-index ID.
// Optional overflow flags at offset 3 when GPIO_IRQ_OVF_EN is defined.
`timescale 1ns/1ps

module as_gpio_irq_ctrl #(
   parameter int unsigned NR_GPIOS = 8,
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DATA_W   = 32
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NR_GPIOS-1:0] irq_pulse_i,
   input  logic                en_i,
   input  logic                we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rvalid_o,
   output logic                irq_o,
   output logic [4:0]          irq_id_o
);

   localparam int unsigned ID_W = 5;
   localparam logic [ADDR_W-1:0] A_IE   = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_ID   = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_OVF  = ADDR_W'(3);

   logic [NR_GPIOS-1:0] r_ie;
   logic [NR_GPIOS-1:0] r_pend;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rvalid;
   logic                r_irq;
   logic [ID_W-1:0]     r_irq_id;

   logic                w_wr;
   logic                w_rd;
   logic [NR_GPIOS-1:0] w_pend_clr;
   logic [NR_GPIOS-1:0] w_act;
   logic [ID_W-1:0]     w_id;
   logic [DATA_W-1:0]   w_rd_mux;
   logic                w_unused_wdata;

   assign w_wr           = en_i & we_i;
   assign w_rd           = en_i & ~we_i;
   assign w_pend_clr     = (w_wr && addr_i == A_PEND) ? wdata_i[NR_GPIOS-1:0] : '0;
   assign w_act          = r_pend & r_ie;
   assign w_unused_wdata = ^wdata_i[DATA_W-1:NR_GPIOS];

`ifdef GPIO_IRQ_OVF_EN
   logic [NR_GPIOS-1:0] r_ovf;
   logic [NR_GPIOS-1:0] w_ovf_clr;
   logic [NR_GPIOS-1:0] w_ovf_set;

   // A repeat pulse only counts as overflow if the pending bit survives this cycle.
   assign w_ovf_clr = (w_wr && addr_i == A_OVF) ? wdata_i[NR_GPIOS-1:0] : '0;
   assign w_ovf_set = irq_pulse_i & r_pend & ~w_pend_clr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_ovf <= '0;
      else       r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
   end
`endif

   // Lowest-numbered active bit wins.
   always_comb begin
      w_id = '0;
      for (int k = int'(NR_GPIOS) - 1; k >= 0; k--) begin
         if (w_act[k]) w_id = ID_W'(k);
      end
   end

   // Read mux sees pre-update register contents.
   always_comb begin
      w_rd_mux = '0;
      case (addr_i)
         A_IE:   w_rd_mux = DATA_W'(r_ie);
         A_PEND: w_rd_mux = DATA_W'(r_pend);
         A_ID: begin
            w_rd_mux[ID_W-1:0]  = r_irq_id;
            w_rd_mux[DATA_W-1]  = r_irq;
         end
`ifdef GPIO_IRQ_OVF_EN
         A_OVF:  w_rd_mux = DATA_W'(r_ovf);
`endif
         default: w_rd_mux = '0;
      endcase
   end

   // Pulse set takes priority over a same-cycle W1C so no event is lost.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ie     <= '0;
         r_pend   <= '0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_irq    <= 1'b0;
         r_irq_id <= '0;
      end else begin
         if (w_wr && addr_i == A_IE) r_ie <= wdata_i[NR_GPIOS-1:0];
         r_pend   <= (r_pend & ~w_pend_clr) | irq_pulse_i;
         r_rvalid <= w_rd;
         if (w_rd) r_rdata <= w_rd_mux;
         r_irq    <= |w_act;
         r_irq_id <= w_id;
      end
   end

   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign irq_o    = r_irq;
   assign irq_id_o = r_irq_id;

endmodule

// File: tb/tb_as_gpio_irq_ctrl.sv
// Directed self-checking bench for as_gpio_irq_ctrl; OVF expectations follow GPIO_IRQ_OVF_EN.
`timescale 1ns/1ps

module tb_as_gpio_irq_ctrl;

   localparam int unsigned NR_GPIOS = 8;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned DATA_W   = 32;

`ifdef GPIO_IRQ_OVF_EN
   localparam logic [31:0] OVF_B4 = 32'h10;
`else
   localparam logic [31:0] OVF_B4 = 32'h0;
`endif

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic [NR_GPIOS-1:0] irq_pulse_i = '0;
   logic                en_i = 1'b0;
   logic                we_i = 1'b0;
   logic [ADDR_W-1:0]   addr_i = '0;
   logic [DATA_W-1:0]   wdata_i = '0;
   logic [DATA_W-1:0]   rdata_o;
   logic                rvalid_o;
   logic                irq_o;
   logic [4:0]          irq_id_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd;

   as_gpio_irq_ctrl #(.NR_GPIOS(NR_GPIOS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .irq_pulse_i(irq_pulse_i),
      .en_i(en_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rdata_o(rdata_o), .rvalid_o(rvalid_o), .irq_o(irq_o), .irq_id_o(irq_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      en_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
      tick();
      en_i = 1'b0; we_i = 1'b0; wdata_i = '0;
   endtask

   task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
      en_i = 1'b1; we_i = 1'b0; addr_i = a;
      tick();
      en_i = 1'b0;
      check("rvalid_on_read", 32'(rvalid_o), 32'h1);
      d = rdata_o;
   endtask

   task automatic pulse(input logic [NR_GPIOS-1:0] m);
      irq_pulse_i = m;
      tick();
      irq_pulse_i = '0;
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_irq",    32'(irq_o),    32'h0);
      check("rst_id",     32'(irq_id_o), 32'h0);
      check("rst_rvalid", 32'(rvalid_o), 32'h0);
      check("rst_rdata",  rdata_o,       32'h0);
      rst_i = 1'b0;
      tick();

      // T2: enable bits 0,2; pulse bit 2
      bus_write(4'd0, 32'h05);
      pulse(8'h04);
      check("t2_irq_n1", 32'(irq_o), 32'h0);
      tick();
      check("t2_irq_n2", 32'(irq_o),    32'h1);
      check("t2_id_n2",  32'(irq_id_o), 32'h2);
      bus_read(4'd2, rd);
      check("t2_id_reg", rd, 32'h8000_0002);
      tick();
      check("t2_rvalid_drop", 32'(rvalid_o), 32'h0);
      check("t2_rdata_hold",  rdata_o,       32'h8000_0002);
      bus_write(4'd1, 32'h04);
      bus_write(4'd0, 32'h00);
      tick();
      check("t2_cleared", 32'(irq_o), 32'h0);

      // T3: pending while masked, then enable
      pulse(8'h08);
      tick(); tick();
      check("t3_masked_irq", 32'(irq_o), 32'h0);
      bus_read(4'd1, rd);
      check("t3_pend", rd, 32'h08);
      bus_write(4'd0, 32'h08);
      check("t3_ie_n1", 32'(irq_o), 32'h0);
      tick();
      check("t3_ie_n2", 32'(irq_o),    32'h1);
      check("t3_id",    32'(irq_id_o), 32'h3);

      // T4: pend=0x09, IE=0xFF, W1C moves ID then drops IRQ
      pulse(8'h01);
      bus_write(4'd0, 32'hFF);
      tick();
      check("t4_id0", 32'(irq_id_o), 32'h0);
      bus_write(4'd1, 32'h01);
      check("t4_id_n1", 32'(irq_id_o), 32'h0);
      tick();
      check("t4_id_n2", 32'(irq_id_o), 32'h3);
      bus_write(4'd1, 32'h08);
      check("t4_irq_n1", 32'(irq_o), 32'h1);
      tick();
      check("t4_irq_n2", 32'(irq_o),    32'h0);
      check("t4_id_idle", 32'(irq_id_o), 32'h0);

      // T5: pulse and W1C on the same bit, set wins
      pulse(8'h02);
      irq_pulse_i = 8'h02;
      bus_write(4'd1, 32'h02);
      irq_pulse_i = '0;
      bus_read(4'd1, rd);
      check("t5_pend", rd, 32'h02);
      bus_read(4'd3, rd);
      check("t5_ovf", rd, 32'h0);
      // Read in the cycle of a pulse returns the old value
      irq_pulse_i = 8'h20;
      bus_read(4'd1, rd);
      irq_pulse_i = '0;
      check("rd_pre_update", rd, 32'h02);
      bus_read(4'd1, rd);
      check("rd_post_update", rd, 32'h22);
      bus_write(4'd1, 32'hFF);

      // T6: overflow on repeated pulse
      pulse(8'h10);
      pulse(8'h10);
      bus_read(4'd3, rd);
      check("t6_ovf_set", rd, OVF_B4);
      check("t6_irq",    32'(irq_o),    32'h1);
      check("t6_id",     32'(irq_id_o), 32'h4);
      bus_write(4'd3, 32'h10);
      bus_read(4'd3, rd);
      check("t6_ovf_clr", rd, 32'h0);
      bus_write(4'd1, 32'h10);
      tick();
      check("t6_irq_off", 32'(irq_o), 32'h0);

      // Unmapped offset and IE upper bits
      bus_write(4'd5, 32'hDEAD_BEEF);
      bus_read(4'd5, rd);
      check("unmapped", rd, 32'h0);
      bus_write(4'd0, 32'hFFFF_FF00);
      bus_read(4'd0, rd);
      check("ie_upper", rd, 32'h0);
      bus_write(4'd2, 32'hFFFF_FFFF);
      bus_read(4'd2, rd);
      check("id_ro", rd, 32'h0);

      // T1: reset mid-traffic
      bus_write(4'd0, 32'hFF);
      pulse(8'h01);
      tick();
      check("t1_pre_irq", 32'(irq_o), 32'h1);
      en_i = 1'b1; we_i = 1'b0; addr_i = 4'd1;
      tick();
      #2;
      rst_i = 1'b1;
      #1;
      check("t1_async_irq",    32'(irq_o),    32'h0);
      check("t1_async_rvalid", 32'(rvalid_o), 32'h0);
      check("t1_async_rdata",  rdata_o,       32'h0);
      irq_pulse_i = 8'h04;
      tick();
      check("t1_in_rst_rvalid", 32'(rvalid_o), 32'h0);
      en_i = 1'b0;
      irq_pulse_i = '0;
      rst_i = 1'b0;
      tick();
      check("t1_post_rvalid", 32'(rvalid_o), 32'h0);
      bus_read(4'd1, rd);
      check("t1_pend", rd, 32'h0);
      bus_read(4'd0, rd);
      check("t1_ie", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
